// File: rtl/gray_cnt.sv
// ---------------------------------------------------------------------------
// gray_cnt -- registered up/down Gray-code counter
//
// Keeps a binary count internally and registers its Gray encoding on the same
// edge, so `gray` always encodes the current count and moves one bit per step.
// A synchronous binary load overrides counting. `wrap` pulses for one cycle
// on every edge where the count rolls over (all-ones -> 0 going up,
// 0 -> all-ones going down).
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset (clears count, gray, wrap)
//   en        in   count enable, one step per cycle while high
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   synchronous load strobe, highest priority
//   load_val  in   binary value to load
//   gray      out  registered Gray code of the count (feeds g2b)
//   wrap      out  registered one-cycle wrap pulse
// ---------------------------------------------------------------------------
module gray_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_cnt;
    logic             next_wrap;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One extra bit on the sum/difference captures the carry or borrow; the
    // low WIDTH bits are the modulo result and the top bit flags the wrap.
    assign inc_ext = {1'b0, cnt} + ONE;
    assign dec_ext = {1'b0, cnt} - ONE;

    always_comb begin
        next_cnt  = cnt;
        next_wrap = 1'b0;
        if (load) begin
            next_cnt = load_val;
        end else if (en) begin
            if (up) begin
                next_cnt  = inc_ext[WIDTH-1:0];
                next_wrap = inc_ext[WIDTH];
            end else begin
                next_cnt  = dec_ext[WIDTH-1:0];
                next_wrap = dec_ext[WIDTH];
            end
        end
    end

    // gray is encoded from next_cnt rather than cnt so it never lags the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= next_cnt;
            gray <= bin_to_gray(next_cnt);
            wrap <= next_wrap;
        end
    end

endmodule
